// File: rtl/fifo64_pixel_unpack_if.sv
// Bundle of the FIFO read-side and pixel-stream signals of the word-to-pixel unpacker.
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. pix_data/pix_* flags are meaningful only while pix_vld is high, and
// stay stable while pix_vld is high and pix_rdy is low. On the FIFO side,
// fifo_rd_en is a pop strobe that is only raised while fifo_rd_vld is high.
interface fifo64_pixel_unpack_if;
    logic        fifo_rd_vld;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        pix_vld;
    logic        pix_rdy;
    logic [7:0]  pix_data;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_sof;
    logic        pix_eof;
    logic        frame_done;

    // Unpacker side.
    modport slave (
        input  fifo_rd_vld, fifo_rd_data, pix_rdy,
        output fifo_rd_en, pix_vld, pix_data, pix_sol, pix_eol, pix_sof, pix_eof, frame_done
    );

    // Environment side: owns the FIFO head and the pixel sink.
    modport master (
        output fifo_rd_vld, fifo_rd_data, pix_rdy,
        input  fifo_rd_en, pix_vld, pix_data, pix_sol, pix_eol, pix_sof, pix_eof, frame_done
    );
endinterface

// File: rtl/fifo64_pixel_unpack.sv
// Serialises 64-bit FIFO words into an 8-bit pixel stream, byte 0 first,
// tagging line/frame boundaries and discarding the pad bytes that follow the
// last pixel of a frame so that each frame starts at byte 0 of a fresh word.
module fifo64_pixel_unpack #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    fifo64_pixel_unpack_if.slave bus
);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [63:0]      word_q, word_d;
    logic             word_vld_q, word_vld_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             frame_done_q, frame_done_d;

    logic fire;
    logic last_pix;
    logic last_byte;
    logic pop;

    assign fire      = word_vld_q & bus.pix_rdy;
    assign last_pix  = (col_q == COL_LAST) & (row_q == ROW_LAST);
    // The eof pixel ends the word early: any bytes after it are frame padding.
    assign last_byte = (idx_q == 3'd7) | last_pix;
    // Refill overlaps the final byte's transfer so words stream without a bubble.
    assign pop       = ~rd_rst & bus.fifo_rd_vld & (~word_vld_q | (fire & last_byte));

    assign bus.fifo_rd_en = pop;
    assign bus.pix_vld    = word_vld_q;
    assign bus.pix_data   = word_q[{idx_q, 3'b000} +: 8];
    assign bus.pix_sol    = (col_q == '0);
    assign bus.pix_eol    = (col_q == COL_LAST);
    assign bus.pix_sof    = (col_q == '0) & (row_q == '0);
    assign bus.pix_eof    = last_pix;
    assign bus.frame_done = frame_done_q;

    // Next-state for the holding register, byte pointer and raster counters.
    always_comb begin
        word_d       = word_q;
        word_vld_d   = word_vld_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = fire & last_pix;

        if (pop) begin
            word_d     = bus.fifo_rd_data;
            word_vld_d = 1'b1;
            idx_d      = 3'd0;
        end else if (fire) begin
            if (last_byte) begin
                word_vld_d = 1'b0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        if (fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_ONE;
            end else begin
                col_d = col_q + CNT_ONE;
            end
        end
    end

    // State registers; reset drops any partially consumed word.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            word_q       <= '0;
            word_vld_q   <= 1'b0;
            idx_q        <= 3'd0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            word_q       <= word_d;
            word_vld_q   <= word_vld_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_fifo64_pixel_unpack.sv
// Bench for the word-to-pixel unpacker: two instances (8x2 and 4x3 frames),
// a queue standing in for the prefetch FIFO, and a byte-stream reference
// model that turns each pushed word into the pixels it should yield.
module tb_fifo64_pixel_unpack;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    fifo64_pixel_unpack_if if_a ();
    fifo64_pixel_unpack_if if_b ();

    fifo64_pixel_unpack #(.IMG_W(8), .IMG_H(2), .CNT_W(16)) u_a (
        .rd_clk (clk),
        .rd_rst (rst_a),
        .bus    (if_a.slave)
    );

    fifo64_pixel_unpack #(.IMG_W(4), .IMG_H(3), .CNT_W(16)) u_b (
        .rd_clk (clk),
        .rd_rst (rst_b),
        .bus    (if_b.slave)
    );

    // Observed signals of the currently selected instance.
    bit sel;
    logic       o_vld, o_rden, o_fd, o_sol, o_eol, o_sof, o_eof;
    logic [7:0] o_data;
    assign o_vld  = sel ? if_b.pix_vld    : if_a.pix_vld;
    assign o_rden = sel ? if_b.fifo_rd_en : if_a.fifo_rd_en;
    assign o_fd   = sel ? if_b.frame_done : if_a.frame_done;
    assign o_sol  = sel ? if_b.pix_sol    : if_a.pix_sol;
    assign o_eol  = sel ? if_b.pix_eol    : if_a.pix_eol;
    assign o_sof  = sel ? if_b.pix_sof    : if_a.pix_sof;
    assign o_eof  = sel ? if_b.pix_eof    : if_a.pix_eof;
    assign o_data = sel ? if_b.pix_data   : if_a.pix_data;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents and expected pixels {eof, sof, eol, sol, data}.
    logic [63:0] fifo_q[$];
    logic [11:0] exp_q[$];
    int mw, mh, pos;

    // Per-cycle history and statistics.
    bit          prev_pop, prev_stall, prev_rst, exp_fd_next, tog;
    logic [11:0] prev_obs;
    int cyc, n_fires, n_pops, first_fire, last_fire;
    int fd_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input int base);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(base + b);
        return w;
    endfunction

    // Reference model: a frame consumes mw*mh bytes from the start of a word;
    // whatever is left in the word holding its last pixel is padding.
    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < 8; b++) begin
            int col;
            col = pos % mw;
            exp_q.push_back({pos == mw*mh - 1, pos == 0, col == mw - 1, col == 0, w[b*8 +: 8]});
            pos++;
            if (pos == mw*mh) begin
                pos = 0;
                break;
            end
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        exp_q.delete();
        pos = 0;
    endtask

    task automatic reset_stats();
        n_fires = 0;
        n_pops = 0;
        first_fire = -1;
        last_fire = -1;
        fd_q.delete();
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit rdy, input bit rst);
        if_a.fifo_rd_vld  = sel ? 1'b0 : v;
        if_a.fifo_rd_data = d;
        if_a.pix_rdy      = sel ? 1'b0 : rdy;
        rst_a             = sel ? 1'b0 : rst;
        if_b.fifo_rd_vld  = sel ? v : 1'b0;
        if_b.fifo_rd_data = d;
        if_b.pix_rdy      = sel ? rdy : 1'b0;
        rst_b             = sel ? rst : 1'b0;
    endtask

    // One clock cycle: drive just after the falling edge, check 1 ns later.
    task automatic cycle(input bit rdy, input bit allow, input bit rst);
        bit          vld_in, fire;
        logic [63:0] din;
        logic [11:0] obs, e;
        vld_in = allow && (fifo_q.size() != 0);
        din = vld_in ? fifo_q[0] : {$urandom, $urandom};
        drive(vld_in, din, rdy, rst);
        #1;
        obs = {o_eof, o_sof, o_eol, o_sol, o_data};
        chk("frame_done", o_fd, exp_fd_next);
        if (prev_rst) chk("vld_after_rst", o_vld, 1'b0);
        if (prev_pop) chk("vld_after_pop", o_vld, 1'b1);
        if (prev_stall) begin
            chk("hold_vld", o_vld, 1'b1);
            chk("hold_pix", obs, prev_obs);
        end
        chk("rden_qual", o_rden & ~vld_in, 1'b0);
        if (o_vld && !rdy) chk("no_pop_stall", o_rden, 1'b0);
        if (rst) chk("rden_rst", o_rden, 1'b0);
        fire = o_vld && rdy && !rst;
        exp_fd_next = 1'b0;
        if (fire) begin
            n_fires++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_pix", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("pix", obs, e);
                exp_fd_next = e[11];
            end
        end
        if (o_rden === 1'b1) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            n_pops++;
        end
        if (o_fd === 1'b1) fd_q.push_back(cyc);
        prev_pop   = (o_rden === 1'b1);
        prev_stall = (o_vld === 1'b1) && !rdy && !rst;
        prev_obs   = obs;
        prev_rst   = rst;
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: always ready; 1: ready toggles 1,0,1,...; 2: random ready and FIFO gaps.
    task automatic drain(input int mode);
        int  guard;
        bit  rdy, allow;
        guard = 0;
        tog = 1'b1;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && guard < 2000) begin
            rdy = 1'b1;
            allow = 1'b1;
            if (mode == 1) begin
                rdy = tog;
                tog = ~tog;
            end else if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
                allow = ($urandom_range(0, 2) != 0);
            end
            cycle(rdy, allow, 1'b0);
            guard++;
        end
        if (guard >= 2000) chk("drain_timeout", 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("idle_after_drain", o_vld, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rdy;
        sel = 1'b0;
        cyc = 0;
        prev_pop = 0; prev_stall = 0; prev_rst = 0; exp_fd_next = 0;
        prev_obs = '0;
        mw = 8; mh = 2;
        model_clear();
        reset_stats();
        // Power-on reset of both instances, unchecked while state is unknown.
        if_a.fifo_rd_vld = 1'b0; if_a.fifo_rd_data = '0; if_a.pix_rdy = 1'b0;
        if_b.fifo_rd_vld = 1'b0; if_b.fifo_rd_data = '0; if_b.pix_rdy = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset held with a word available: no pop allowed.
        fifo_q.push_back(64'hDEAD_BEEF_0000_0001);
        cycle(1'b1, 1'b1, 1'b1);
        fifo_q.delete();
        rst_b = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        chk("rst_vld", o_vld, 1'b0);
        chk("rst_rden", o_rden, 1'b0);
        chk("rst_fd", o_fd, 1'b0);

        // 8x2 frame, always ready: 16 back-to-back pixels, two pops.
        reset_stats();
        push_word(mk_word(0));
        push_word(mk_word(8));
        drain(0);
        chk("t1_pops", n_pops, 2);
        chk("t1_fires", n_fires, 16);
        chk("t1_span", last_fire - first_fire, 15);
        chk("t1_fd_cnt", fd_q.size(), 1);
        if (fd_q.size() == 1) chk("t1_fd_when", fd_q[0], last_fire + 1);

        // Same frame with ready toggling: pixels held, no extra pops.
        reset_stats();
        push_word(mk_word(0));
        push_word(mk_word(8));
        drain(1);
        chk("t2_pops", n_pops, 2);
        chk("t2_fires", n_fires, 16);
        chk("t2_fd_cnt", fd_q.size(), 1);

        // 4x3 instance: 12-pixel frames, bytes 0C..0F of the second word dropped.
        sel = 1'b1;
        mw = 4; mh = 3;
        model_clear();
        reset_stats();
        push_word(mk_word(8'h00));
        push_word(mk_word(8'h08));
        push_word(mk_word(8'h10));
        push_word(mk_word(8'h18));
        drain(0);
        chk("t3_pops", n_pops, 4);
        chk("t3_fires", n_fires, 24);
        chk("t3_fd_cnt", fd_q.size(), 2);

        // FIFO empty for 5 cycles between the two words of a frame.
        sel = 1'b0;
        mw = 8; mh = 2;
        model_clear();
        reset_stats();
        push_word(mk_word(8'h20));
        drain(0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            chk("gap_vld", o_vld, 1'b0);
        end
        push_word(mk_word(8'h28));
        drain(0);
        chk("t4_pops", n_pops, 2);
        chk("t4_fd_cnt", fd_q.size(), 1);

        // Reset after pixel 03: partial word lost, next word starts a frame.
        reset_stats();
        push_word(mk_word(8'h40));
        push_word(mk_word(8'h48));
        for (int i = 0; i < 50 && n_fires < 4; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("t5_fires_before_rst", n_fires, 4);
        cycle(1'b0, 1'b1, 1'b1);
        model_clear();
        cycle(1'b1, 1'b1, 1'b0);
        chk("t5_vld_cleared", o_vld, 1'b0);
        reset_stats();
        push_word(mk_word(8'h60));
        push_word(mk_word(8'h68));
        drain(0);
        chk("t5_fires_after", n_fires, 16);
        chk("t5_fd_cnt", fd_q.size(), 1);

        // Three continuous frames: 48 fires, no idle cycle, done pulses 16 apart.
        reset_stats();
        for (int f = 0; f < 6; f++) push_word(mk_word(8'h80 + f*8));
        drain(0);
        chk("t6_fires", n_fires, 48);
        chk("t6_span", last_fire - first_fire, 47);
        chk("t6_fd_cnt", fd_q.size(), 3);
        if (fd_q.size() == 3) begin
            chk("t6_fd_gap1", fd_q[1] - fd_q[0], 16);
            chk("t6_fd_gap2", fd_q[2] - fd_q[1], 16);
        end

        // Random data, random ready and FIFO availability on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            mw = sel ? 4 : 8;
            mh = sel ? 3 : 2;
            model_clear();
            reset_stats();
            for (int k = 0; k < 12; k++) push_word({$urandom, $urandom});
            drain(2);
            chk("rand_pops", n_pops, 12);
            chk("rand_fd_cnt", fd_q.size(), sel ? 6 : 6);
        end

        // Random ready with a sudden reset, then a clean frame.
        sel = 1'b1;
        mw = 4; mh = 3;
        model_clear();
        reset_stats();
        for (int k = 0; k < 4; k++) push_word({$urandom, $urandom});
        for (int i = 0; i < 9; i++) begin
            rdy = ($urandom_range(0, 1) != 0);
            cycle(rdy, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b1);
        model_clear();
        push_word({$urandom, $urandom});
        push_word({$urandom, $urandom});
        drain(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
